// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO access bundle between the control unit and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [2:0]            MulDivOp;
  logic [DATA_WIDTH-1:0] OperandA;
  logic [DATA_WIDTH-1:0] OperandB;
  logic                  HiWrite;
  logic                  LoWrite;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Stall;
  logic                  Busy;
  logic                  Done;
  logic                  DivByZero;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (
    output Start, MulDivOp, OperandA, OperandB, HiWrite, LoWrite, WriteData,
    input  Stall, Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, MulDivOp, OperandA, OperandB, HiWrite, LoWrite, WriteData,
    output Stall, Busy, Done, DivByZero, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO: one shift-add or restoring-divide bit per clock,
// operating on magnitudes with a final sign-fix cycle.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [N-1:0]    hi;
  logic [N-1:0]    lo;
  logic [N-1:0]    opb;
  logic [2*N-1:0]  acc;

  logic            valid_start;
  logic            op_div;
  logic            op_signed;
  logic [N:0]      mul_sum;
  logic [N:0]      div_shift;
  logic [N:0]      div_diff;
  logic [2*N-1:0]  prod_fixed;
  logic [N-1:0]    quot_fixed;
  logic [N-1:0]    rem_fixed;

  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v, input logic use_sign);
    return (use_sign && v[N-1]) ? -v : v;
  endfunction

  function automatic logic [N-1:0] fix_word(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] fix_dword(input logic [2*N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign valid_start = bus.Start && (bus.MulDivOp[2] == 1'b0);
  assign op_div      = bus.MulDivOp[1];
  assign op_signed   = bus.MulDivOp[0];

  // acc holds {partial product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum    = {1'b0, acc[2*N-1:N]} + {1'b0, opb & {N{acc[0]}}};
    div_shift  = acc[2*N-1:N-1];
    div_diff   = div_shift - {1'b0, opb};
    prod_fixed = fix_dword(acc, neg_q);
    quot_fixed = fix_word(acc[N-1:0], neg_q);
    rem_fixed  = fix_word(acc[2*N-1:N], neg_r);
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && valid_start) begin
      opb <= magnitude(bus.OperandB, op_signed);
      acc <= {{N{1'b0}}, magnitude(bus.OperandA, op_signed)};
    end else if (state == CALC) begin
      if (is_div)
        acc <= div_diff[N] ? {div_shift[N-1:0], acc[N-2:0], 1'b0}
                           : {div_diff[N-1:0], acc[N-2:0], 1'b1};
      else
        acc <= {mul_sum, acc[N-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_start) begin
            is_div <= op_div;
            neg_q  <= op_signed & (bus.OperandA[N-1] ^ bus.OperandB[N-1]);
            neg_r  <= op_signed & bus.OperandA[N-1];
            if (op_div && bus.OperandB == '0) begin
              hi          <= bus.OperandA;
              lo          <= '1;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              count <= CW'(DATA_WIDTH);
              busy  <= 1'b1;
              state <= CALC;
            end
          end else begin
            if (bus.HiWrite) hi <= bus.WriteData;
            if (bus.LoWrite) lo <= bus.WriteData;
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fixed;
            lo <= quot_fixed;
          end else begin
            hi <= prod_fixed[2*N-1:N];
            lo <= prod_fixed[N-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Stall     = (state == IDLE && valid_start) || (state == CALC) || (state == FIX);
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = div_by_zero;
  assign bus.HI        = hi;
  assign bus.LO        = lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, hand-written corner sequences, and random ops
// against an arithmetic reference model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();
  muldiv_sequencer #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input bit poke_hi, input string tag);
    int lat, stalls;
    bit held, busy_ok, got;
    bus.Start = 1'b1; bus.MulDivOp = op; bus.OperandA = a; bus.OperandB = b;
    #1;
    check({tag, ".stall_accept"}, bus.Stall, 1);
    lat = 0; stalls = 0; held = 1; busy_ok = 1; got = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      lat++;
      if (poke_hi) begin
        bus.HiWrite = (lat == 5);
        bus.WriteData = 32'h1234;
      end
      if (bus.Done) begin
        got = 1;
        break;
      end
      if (bus.Stall) stalls++;
      if (!bus.Busy) busy_ok = 0;
      if (bus.HI !== m_hi || bus.LO !== m_lo) held = 0;
    end
    bus.HiWrite = 1'b0;
    check({tag, ".done_seen"}, got, 1);
    check({tag, ".latency"}, lat, edz ? 1 : W + 2);
    check({tag, ".stall_cycles"}, stalls, edz ? 0 : W + 1);
    if (!edz) check({tag, ".busy_calc"}, busy_ok, 1);
    check({tag, ".hilo_hold"}, held, 1);
    check({tag, ".done_stall"}, bus.Stall, 0);
    check({tag, ".done_busy"}, bus.Busy, 0);
    check({tag, ".divbyzero"}, bus.DivByZero, edz);
    check({tag, ".hi"}, bus.HI, ehi);
    check({tag, ".lo"}, bus.LO, elo);
    m_hi = ehi;
    m_lo = elo;
    cyc();
    bus.Start = 1'b0;
    #1;
    check({tag, ".idle_busy"}, bus.Busy, 0);
    check({tag, ".idle_done"}, bus.Done, 0);
    check({tag, ".idle_stall"}, bus.Stall, 0);
  endtask

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rdz;
    logic [2:0]  rop;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[7]  = '{3'd2, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[8]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};

    reset = 1'b1;
    bus.Start = 1'b0; bus.MulDivOp = '0; bus.OperandA = '0; bus.OperandB = '0;
    bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WriteData = '0;
    cyc();
    cyc();
    check("rst.busy", bus.Busy, 0);
    check("rst.done", bus.Done, 0);
    check("rst.dz", bus.DivByZero, 0);
    check("rst.stall", bus.Stall, 0);
    check("rst.hi", bus.HI, 0);
    check("rst.lo", bus.LO, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0,
             $sformatf("vec%0d", i));

    // reset in the middle of a MULTU, then a fresh operation
    bus.Start = 1'b1; bus.MulDivOp = 3'd0; bus.OperandA = 32'hFFFF_FFFF; bus.OperandB = 32'h3;
    for (int i = 0; i < 10; i++) cyc();
    check("midrst.busy_before", bus.Busy, 1);
    bus.Start = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst.busy", bus.Busy, 0);
    check("midrst.stall", bus.Stall, 0);
    check("midrst.hi", bus.HI, 0);
    check("midrst.lo", bus.LO, 0);
    m_hi = '0; m_lo = '0;
    cyc();
    reset = 1'b0;
    cyc();
    run_op(3'd0, 32'hFFFF_FFFF, 32'h3, 32'h2, 32'hFFFF_FFFD, 1'b0, 1'b0, "after_rst");

    // MTHI pulse during CALC must be ignored; Start held through DONE
    run_op(3'd0, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 1'b1, "poke");

    bus.HiWrite = 1'b1; bus.LoWrite = 1'b1; bus.WriteData = 32'hABCD;
    cyc();
    bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
    check("mt.hi", bus.HI, 32'h0000_ABCD);
    check("mt.lo", bus.LO, 32'h0000_ABCD);
    m_hi = 32'hABCD; m_lo = 32'hABCD;

    // invalid opcode is not a start, so MTLO in the same cycle goes through
    bus.Start = 1'b1; bus.MulDivOp = 3'b111; bus.LoWrite = 1'b1; bus.WriteData = 32'h5555;
    #1;
    check("inv.stall", bus.Stall, 0);
    cyc();
    bus.LoWrite = 1'b0;
    check("inv.lo", bus.LO, 32'h5555);
    check("inv.hi", bus.HI, m_hi);
    check("inv.busy", bus.Busy, 0);
    cyc();
    check("inv.busy2", bus.Busy, 0);
    check("inv.done", bus.Done, 0);
    bus.Start = 1'b0;
    m_lo = 32'h5555;

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      model(rop, ra, rb, rhi, rlo, rdz);
      run_op(rop, ra, rb, rhi, rlo, rdz, 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
